read_arbiter: RTL

//  Responder end of the per-group read interface. One instance per image group.

---
 rtl/read_arbiter_if.sv | 32 +++
 rtl/read_arbiter.sv | 107 ++++++++++
 2 files changed

// File: rtl/read_arbiter_if.sv
// Per-group read interface: requester ports on one side, the group's banked buffer on the other.
// slave = arbiter side, master = requester/buffer side.
interface read_arbiter_if #(
  parameter int PORT_NUM   = 3,
  parameter int ROW_PARA   = 4,
  parameter int ADDR_WIDTH = 48,
  parameter int DATA_WIDTH = 256
);
  logic [PORT_NUM-1:0]            read_en_i;
  logic [PORT_NUM*ROW_PARA-1:0]   read_bank_en_i;
  logic [PORT_NUM*ADDR_WIDTH-1:0] read_addr_i;
  logic [PORT_NUM-1:0]            read_addr_ready_o;
  logic [PORT_NUM-1:0]            read_nostall_i;
  logic [PORT_NUM-1:0]            read_data_valid_o;
  logic [DATA_WIDTH-1:0]          read_data_o;
  logic                           mem_rd_en_o;
  logic [ROW_PARA-1:0]            mem_bank_en_o;
  logic [ADDR_WIDTH-1:0]          mem_addr_o;
  logic [DATA_WIDTH-1:0]          mem_data_i;

  modport slave (
    input  read_en_i, read_bank_en_i, read_addr_i, read_nostall_i, mem_data_i,
    output read_addr_ready_o, read_data_valid_o, read_data_o,
    output mem_rd_en_o, mem_bank_en_o, mem_addr_o
  );

  modport master (
    output read_en_i, read_bank_en_i, read_addr_i, read_nostall_i, mem_data_i,
    input  read_addr_ready_o, read_data_valid_o, read_data_o,
    input  mem_rd_en_o, mem_bank_en_o, mem_addr_o
  );
endinterface

// File: rtl/read_arbiter.sv
// Round-robin read arbiter for one image group: grants one port per cycle, issues the buffer read
// and steers data back after MEM_LATENCY+2 cycles. READ_ARBITER_PERF_EN adds stall_cnt_o.
module read_arbiter #(
  parameter int PORT_NUM    = 3,
  parameter int ROW_PARA    = 4,
  parameter int ADDR_WIDTH  = 48,
  parameter int DATA_WIDTH  = 256,
  parameter int MEM_LATENCY = 3
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef READ_ARBITER_PERF_EN
  output logic [31:0]  stall_cnt_o,
`endif
  read_arbiter_if.slave bus
);

  localparam int PTR_W = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

  logic [PORT_NUM-1:0]   eligible;
  logic [PORT_NUM-1:0]   grant;
  logic [PTR_W-1:0]      grant_idx;
  logic                  grant_any;
  logic [PTR_W-1:0]      ptr_reg;
  logic                  mem_rd_en_reg;
  logic [ROW_PARA-1:0]   mem_bank_en_reg;
  logic [ADDR_WIDTH-1:0] mem_addr_reg;
  logic [PORT_NUM-1:0]   tag_pipe_reg [MEM_LATENCY+1];
  logic [PORT_NUM-1:0]   data_valid_reg;
  logic [DATA_WIDTH-1:0] data_reg;
  logic [ADDR_WIDTH-1:0] port_addr [PORT_NUM];
  logic [ROW_PARA-1:0]   port_bank [PORT_NUM];

  genvar gi;
  generate
    for (gi = 0; gi < PORT_NUM; gi++) begin : g_unpack
      assign port_addr[gi] = bus.read_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign port_bank[gi] = bus.read_bank_en_i[gi*ROW_PARA +: ROW_PARA];
      assign eligible[gi]  = bus.read_en_i[gi] & bus.read_nostall_i[gi];
    end
  endgenerate

  // Search starts just after the last granted port so every eligible port is reached in turn.
  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 1; k <= PORT_NUM; k++) begin
      idx = (int'(ptr_reg) + k) % PORT_NUM;
      if (!grant_any && eligible[idx]) begin
        grant_any  = 1'b1;
        grant_idx  = PTR_W'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

  assign bus.read_addr_ready_o = rst_n ? grant : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg         <= PTR_W'(PORT_NUM - 1);
      mem_rd_en_reg   <= 1'b0;
      mem_bank_en_reg <= '0;
      mem_addr_reg    <= '0;
      data_valid_reg  <= '0;
      data_reg        <= '0;
      for (int i = 0; i <= MEM_LATENCY; i++) tag_pipe_reg[i] <= '0;
    end else begin
      mem_rd_en_reg <= grant_any;
      if (grant_any) begin
        ptr_reg         <= grant_idx;
        mem_bank_en_reg <= port_bank[grant_idx];
        mem_addr_reg    <= port_addr[grant_idx];
      end
      // One-hot owner travels alongside the buffer read so data needs no lookup on return.
      tag_pipe_reg[0] <= grant;
      for (int i = 1; i <= MEM_LATENCY; i++) tag_pipe_reg[i] <= tag_pipe_reg[i-1];
      data_valid_reg <= tag_pipe_reg[MEM_LATENCY];
      if (|tag_pipe_reg[MEM_LATENCY]) data_reg <= bus.mem_data_i;
    end
  end

  assign bus.mem_rd_en_o       = mem_rd_en_reg;
  assign bus.mem_bank_en_o     = mem_bank_en_reg;
  assign bus.mem_addr_o        = mem_addr_reg;
  assign bus.read_data_valid_o = data_valid_reg;
  assign bus.read_data_o       = data_reg;

`ifdef READ_ARBITER_PERF_EN
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else if ((|(bus.read_en_i & ~bus.read_nostall_i)) && !grant_any
                 && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_reg;
`endif

endmodule
